// File: rtl/quad_step_decoder_if.sv
// Encoder-side bundle for quad_step_decoder: raw phases and clear in, step/direction/position out.
interface quad_step_decoder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             a_in;
    logic             b_in;
    logic             clr;
    logic             step;
    logic             ud;
    logic             err;
    logic             err_sticky;
    logic [WIDTH-1:0] pos;

    // Drives the encoder pins and clear, observes the decoded outputs.
    modport master (
        output a_in, b_in, clr,
        input  step, ud, err, err_sticky, pos
    );

    // The decoder itself.
    modport slave (
        input  a_in, b_in, clr,
        output step, ud, err, err_sticky, pos
    );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronises an A/B encoder pair, emits a one-cycle step strobe with
// direction, keeps a wrapping position count and flags double-phase (illegal) transitions.
// Optional feature macro: GLITCH_FILTER_EN adds a per-phase hold filter of FILT_LEN cycles.
// The interface WIDTH parameter must match this module's WIDTH.
module quad_step_decoder #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
`ifdef GLITCH_FILTER_EN
    ,
    parameter int unsigned FILT_LEN    = 4
`endif
) (
    input logic             clk,
    input logic             reset,
    quad_step_decoder_if.slave bus
);

    typedef enum logic [0:0] {StPrime, StRun} state_e;

`ifdef GLITCH_FILTER_EN
    localparam int unsigned PrimeLen = SYNC_STAGES + FILT_LEN + 1;
`else
    localparam int unsigned PrimeLen = SYNC_STAGES + 1;
`endif
    localparam int unsigned PcW = $clog2(PrimeLen);

    logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
    logic [1:0]             sync_ab;
    logic [1:0]             cur;
    logic [1:0]             prev_q;
    logic [1:0]             delta;
    state_e                 state_q;
    logic [PcW-1:0]         pcnt_q;
    logic                   step_q, ud_q, err_q, err_sticky_q;
    logic [WIDTH-1:0]       pos_q;

    // Two-or-more flop synchroniser per phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], bus.a_in};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], bus.b_in};
        end
    end

    assign sync_ab = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

`ifdef GLITCH_FILTER_EN
    localparam int unsigned FcW = $clog2(FILT_LEN + 1);

    logic [1:0]     filt_q;
    logic [FcW-1:0] fcnt_q [2];

    // Accept a new phase level only after it has differed from the filtered one for FILT_LEN cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= '0;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_ab[i] != filt_q[i]) begin
                    if (fcnt_q[i] == FcW'(FILT_LEN - 1)) begin
                        filt_q[i] <= sync_ab[i];
                        fcnt_q[i] <= '0;
                    end else begin
                        fcnt_q[i] <= fcnt_q[i] + FcW'(1);
                    end
                end else begin
                    fcnt_q[i] <= '0;
                end
            end
        end
    end

    assign cur = filt_q;
`else
    assign cur = sync_ab;
`endif

    // Position of a phase pair along the Gray cycle 00->01->11->10.
    function automatic logic [1:0] gray_idx(input logic [1:0] g);
        logic [1:0] r;
        case (g)
            2'b00:   r = 2'd0;
            2'b01:   r = 2'd1;
            2'b11:   r = 2'd2;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    // 1 = one step forward, 3 = one step back, 2 = both phases flipped, 0 = idle.
    assign delta = gray_idx(cur) - gray_idx(prev_q);

    // Prime/run FSM with registered step, direction, error and position outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StPrime;
            pcnt_q       <= '0;
            prev_q       <= '0;
            step_q       <= 1'b0;
            ud_q         <= 1'b1;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            pos_q        <= '0;
        end else begin
            step_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StPrime: begin
                    // Wait for the pipeline to fill so a static input is taken as the start point.
                    if (pcnt_q == PcW'(PrimeLen - 1)) begin
                        prev_q  <= cur;
                        state_q <= StRun;
                    end else begin
                        pcnt_q <= pcnt_q + PcW'(1);
                    end
                end
                default: begin
                    prev_q <= cur;
                    case (delta)
                        2'd1: begin
                            step_q <= 1'b1;
                            ud_q   <= 1'b1;
                            pos_q  <= pos_q + WIDTH'(1);
                        end
                        2'd3: begin
                            step_q <= 1'b1;
                            ud_q   <= 1'b0;
                            pos_q  <= pos_q - WIDTH'(1);
                        end
                        2'd2: begin
                            err_q        <= 1'b1;
                            err_sticky_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            endcase
            // Clear overrides any same-cycle count or error capture.
            if (bus.clr) begin
                pos_q        <= '0;
                err_sticky_q <= 1'b0;
            end
        end
    end

    assign bus.step       = step_q;
    assign bus.ud         = ud_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.pos        = pos_q;

endmodule
